// File: rtl/conv_pkg.sv
// Shared widths, coefficient indices and reset kernel for the 3x3 convolution stage.
package conv_pkg;

  localparam int DW_DEF   = 8;
  localparam int CW_DEF   = 8;
  localparam int PROD_W   = DW_DEF + 1 + CW_DEF;  // zero-extended pixel times signed coef
  localparam int ROW_W    = PROD_W + 2;
  localparam int ACC_W    = ROW_W + 2;
  localparam int NUM_COEF = 9;

  localparam int COEF_TL = 0;
  localparam int COEF_TC = 1;
  localparam int COEF_TR = 2;
  localparam int COEF_ML = 3;
  localparam int COEF_C  = 4;
  localparam int COEF_MR = 5;
  localparam int COEF_BL = 6;
  localparam int COEF_BC = 7;
  localparam int COEF_BR = 8;

  // Identity kernel: unity gain on the centre tap once the output shift is applied.
  function automatic logic signed [CW_DEF-1:0] ident_coef(input int idx, input int shift);
    logic signed [CW_DEF-1:0] v;
    v = '0;
    if (idx == COEF_C) v = CW_DEF'(1 << shift);
    return v;
  endfunction

endpackage

// File: rtl/conv_row_mac.sv
// One kernel row: three registered products, then a registered row sum (stages 1-2).
module conv_row_mac
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                     clk,
  input  logic [DW-1:0]            pix_a,
  input  logic [DW-1:0]            pix_b,
  input  logic [DW-1:0]            pix_c,
  input  logic signed [CW-1:0]     coef_a,
  input  logic signed [CW-1:0]     coef_b,
  input  logic signed [CW-1:0]     coef_c,
  output logic signed [ROW_W-1:0]  row_sum_p2
);

  logic signed [DW:0]         pix_s   [3];
  logic signed [CW-1:0]       coef_s  [3];
  logic signed [PROD_W-1:0]   prod_p1 [3];

  assign pix_s[0]  = {1'b0, pix_a};
  assign pix_s[1]  = {1'b0, pix_b};
  assign pix_s[2]  = {1'b0, pix_c};
  assign coef_s[0] = coef_a;
  assign coef_s[1] = coef_b;
  assign coef_s[2] = coef_c;

  // Stage 1: products
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      prod_p1[i] <= PROD_W'(pix_s[i]) * PROD_W'(coef_s[i]);
    end
  end

  // Stage 2: row sum
  always_ff @(posedge clk) begin
    row_sum_p2 <= ROW_W'(prod_p1[0]) + ROW_W'(prod_p1[1]) + ROW_W'(prod_p1[2]);
  end

endmodule

// File: rtl/conv3x3_stage.sv
// 3x3 convolution stage: loadable signed kernel, round/shift/saturate, line and frame markers.
module conv3x3_stage
  import conv_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int SHIFT = 4,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DW-1:0]        pix1,
  input  logic [DW-1:0]        pix2,
  input  logic [DW-1:0]        pix3,
  input  logic [DW-1:0]        pix4,
  input  logic [DW-1:0]        pix5,
  input  logic [DW-1:0]        pix6,
  input  logic [DW-1:0]        pix7,
  input  logic [DW-1:0]        pix8,
  input  logic [DW-1:0]        pix9,
  input  logic                 coef_we,
  input  logic [3:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 out_valid,
  output logic [DW-1:0]        pix_out,
  output logic                 line_done,
  output logic                 frame_done
);

  localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROWC_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int RND     = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
  localparam int PIX_MAX = (1 << DW) - 1;

  logic [DW-1:0]             win        [NUM_COEF];
  logic signed [CW-1:0]      coef       [NUM_COEF];
  logic signed [ROW_W-1:0]   row_sum_p2 [3];
  logic signed [ACC_W-1:0]   acc_p2;
  logic [DW-1:0]             pix_res;
  logic                      vld_p1, vld_p2;
  logic [COL_W-1:0]          col;
  logic [ROWC_W-1:0]         row;
  logic                      col_last, row_last;

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] biased;
    biased = acc + ACC_W'(RND);
    return biased >>> SHIFT;
  endfunction

  function automatic logic [DW-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [DW-1:0] r;
    if (v < 0)                      r = '0;
    else if (v > ACC_W'(PIX_MAX))   r = '1;
    else                            r = v[DW-1:0];
    return r;
  endfunction

  assign win[0] = pix1;
  assign win[1] = pix2;
  assign win[2] = pix3;
  assign win[3] = pix4;
  assign win[4] = pix5;
  assign win[5] = pix6;
  assign win[6] = pix7;
  assign win[7] = pix8;
  assign win[8] = pix9;

  // The write lands on the same edge that captures products, so a coincident sample sees the old tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++) coef[i] <= CW'(ident_coef(i, SHIFT));
    end else if (coef_we) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (coef_addr == 4'(i)) coef[i] <= coef_data;
      end
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    conv_row_mac #(.DW(DW), .CW(CW)) u_mac (
      .clk        (clk),
      .pix_a      (win[3*r]),
      .pix_b      (win[3*r+1]),
      .pix_c      (win[3*r+2]),
      .coef_a     (coef[3*r]),
      .coef_b     (coef[3*r+1]),
      .coef_c     (coef[3*r+2]),
      .row_sum_p2 (row_sum_p2[r])
    );
  end

  // Stage 3: total, round, shift, clamp
  assign acc_p2  = ACC_W'(row_sum_p2[0]) + ACC_W'(row_sum_p2[1]) + ACC_W'(row_sum_p2[2]);
  assign pix_res = saturate(round_shift(acc_p2));

  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROWC_W'(IMG_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_valid  <= 1'b0;
      pix_out    <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      vld_p1     <= in_valid;
      vld_p2     <= vld_p1;
      out_valid  <= vld_p2;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (vld_p2) begin
        pix_out <= pix_res;
        if (col_last) begin
          col       <= '0;
          line_done <= 1'b1;
          if (row_last) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stage.sv
// Scoreboard bench for conv3x3_stage: randomized windows and kernels against an arithmetic model.
module tb_conv3x3_stage;

  localparam int SHIFT = 4;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  typedef struct {
    int     pix;
    bit     ld;
    bit     fd;
    longint due;
  } exp_t;

  logic              clk, rst, in_valid, coef_we;
  logic [7:0]        p [9];
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              out_valid, line_done, frame_done;
  logic [7:0]        pix_out;

  exp_t   sbq[$];
  int     kmod[9];
  int     out_cnt;
  int     last_pix;
  longint cyc;
  int     n_vec, n_err;

  conv3x3_stage #(.SHIFT(SHIFT), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .pix1(p[0]), .pix2(p[1]), .pix3(p[2]), .pix4(p[3]), .pix5(p[4]),
    .pix6(p[5]), .pix7(p[6]), .pix8(p[7]), .pix9(p[8]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .pix_out(pix_out),
    .line_done(line_done), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Convolution as plain integer arithmetic with floor division for the normalising shift.
  function automatic int ref_pix(input int px[9]);
    int acc, q, d;
    acc = 0;
    for (int i = 0; i < 9; i++) acc += px[i] * kmod[i];
    d = 1 << SHIFT;
    acc += d / 2;
    q = acc / d;
    if ((acc % d) != 0 && acc < 0) q -= 1;
    if (q < 0) return 0;
    if (q > 255) return 255;
    return q;
  endfunction

  function automatic void model_identity();
    for (int i = 0; i < 9; i++) kmod[i] = (i == 4) ? (1 << SHIFT) : 0;
  endfunction

  task automatic step(input bit v, input int px[9], input bit we, input int addr, input int data);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    for (int i = 0; i < 9; i++) p[i] = 8'(px[i]);
    coef_we   = we;
    coef_addr = 4'(addr);
    coef_data = 8'(data);
    if (v) begin
      out_cnt++;
      e.pix = ref_pix(px);
      e.ld  = (out_cnt % IMG_W) == 0;
      e.fd  = (out_cnt % (IMG_W * IMG_H)) == 0;
      e.due = cyc + 3;
      sbq.push_back(e);
    end
    if (we && addr <= 8) kmod[addr] = data;
  endtask

  task automatic idle(input int n);
    int z[9];
    for (int i = 0; i < 9; i++) z[i] = 0;
    for (int i = 0; i < n; i++) step(1'b0, z, 1'b0, 0, 0);
  endtask

  task automatic load_all(input int v);
    int z[9];
    for (int i = 0; i < 9; i++) z[i] = 0;
    for (int a = 0; a < 9; a++) step(1'b0, z, 1'b1, a, v);
  endtask

  task automatic rand_win(output int px[9]);
    for (int i = 0; i < 9; i++) px[i] = int'($urandom_range(0, 255));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_line_done", line_done, 0);
    check("rst_frame_done", frame_done, 0);
    sbq.delete();
    out_cnt  = 0;
    last_pix = 0;
    model_identity();
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("latency_cycle", cyc, e.due);
          check("pix_out", pix_out, e.pix);
          check("line_done", line_done, e.ld);
          check("frame_done", frame_done, e.fd);
          last_pix = e.pix;
        end
      end else begin
        check("bubble_hold_pix", pix_out, last_pix);
        if (line_done || frame_done) check("marker_without_valid", 1, 0);
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          check("missing_out_valid", 0, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int px[9];
    int d;
    bit v, we;
    n_vec = 0; n_err = 0; out_cnt = 0; last_pix = 0;
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    for (int i = 0; i < 9; i++) p[i] = '0;
    model_identity();
    #2;
    check("por_out_valid", out_valid, 0);
    check("por_pix_out", pix_out, 0);
    check("por_line_done", line_done, 0);
    check("por_frame_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // identity kernel straight out of reset
    rand_win(px); px[4] = 8'h7B;
    step(1'b1, px, 1'b0, 0, 0);
    idle(6);

    // all-ones kernel: full-scale and rounding cases
    load_all(1);
    for (int i = 0; i < 9; i++) px[i] = 255;
    step(1'b1, px, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) px[i] = 0;
    px[4] = 8;
    step(1'b1, px, 1'b0, 0, 0);
    idle(4);

    // positive saturation
    step(1'b0, px, 1'b1, 4, 127);
    for (int i = 0; i < 9; i++) px[i] = 0;
    px[4] = 255;
    step(1'b1, px, 1'b0, 0, 0);
    idle(4);

    // negative result clamps to zero
    load_all(-1);
    step(1'b0, px, 1'b1, 4, 0);
    for (int i = 0; i < 9; i++) px[i] = 100;
    step(1'b1, px, 1'b0, 0, 0);
    idle(4);

    // coefficient write coincident with a sample; ignored address
    load_all(0);
    step(1'b0, px, 1'b1, 4, 16);
    rand_win(px); px[4] = 50;
    step(1'b1, px, 1'b1, 4, 0);
    rand_win(px); px[4] = 50;
    step(1'b1, px, 1'b0, 0, 0);
    step(1'b0, px, 1'b1, 4, 16);
    step(1'b0, px, 1'b1, 12, 77);
    rand_win(px); px[4] = 50;
    step(1'b1, px, 1'b0, 0, 0);
    idle(4);

    // random kernels, windows, bubbles and interleaved writes
    for (int n = 0; n < 80; n++) begin
      rand_win(px);
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 4) == 0);
      d  = int'($urandom_range(0, 47)) - 16;
      step(v, px, we, int'($urandom_range(0, 15)), d);
    end
    idle(5);

    // line/frame markers over 20 outputs with bubbles, counted from reset
    @(posedge clk); #3;
    apply_reset();
    for (int n = 0; n < 20; n++) begin
      while ($urandom_range(0, 2) == 0) idle(1);
      rand_win(px);
      step(1'b1, px, 1'b0, 0, 0);
    end
    idle(5);

    // reset while samples are in flight
    load_all(1);
    for (int n = 0; n < 3; n++) begin
      rand_win(px);
      for (int i = 0; i < 9; i++) px[i] = px[i] | 16;
      step(1'b1, px, 1'b0, 0, 0);
    end
    @(posedge clk); #2;
    check("pre_rst_out_valid", out_valid, 1);
    #1;
    apply_reset();
    idle(6);
    rand_win(px);
    step(1'b1, px, 1'b0, 0, 0);
    idle(6);

    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
